even_issue_scoreboard: RTL and testbench

- Issue-gating stage directly upstream of the even execution pipe.
- Tracks, per architectural register (128 x 128-bit), the cycles remaining until an in-flight even-pipe result is written back.
- Stalls any instruction whose sources (RAW) or destination (WAW) are still pending.
- Registers the accepted instruction's control fields (instr_id, unit_id, reg_dst, latency, reg_wr) into the even pipe's input.

---
 rtl/even_issue_scoreboard.sv | 190 +++++++++++++++++++
 tb/tb_even_issue_scoreboard.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/even_issue_scoreboard.sv
// even_issue_scoreboard
// Issue-gating stage in front of the even execution pipe. For each of the
// 128 architectural registers it keeps a countdown of the cycles left until
// an in-flight even-pipe result is written back. RAW and WAW hazards hold
// the incoming instruction. An accepted instruction's control fields are
// registered toward the pipe one cycle later.
//
// Optional build macro: EVEN_SB_FORWARD_EN
//   defined   : a source is ready while its result sits in the final pipe
//               stage (cnt <= 1), because the forwarding unit supplies it.
//   undefined : a source is ready only after write-back (cnt == 0).
// The WAW check is the same in both builds.

module even_issue_scoreboard #(
    parameter int NREG   = 128,
    parameter int LAT_W  = 4,
    parameter int CNT_W  = 5,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_instr_id,
    input  logic [2:0]        in_unit_id,
    input  logic [6:0]        in_reg_dst,
    input  logic [LAT_W-1:0]  in_latency,
    input  logic              in_reg_wr,
    input  logic [6:0]        in_ra_addr,
    input  logic [6:0]        in_rb_addr,
    input  logic [6:0]        in_rc_addr,
    input  logic              in_ra_used,
    input  logic              in_rb_used,
    input  logic              in_rc_used,
    output logic              out_valid,
    output logic [6:0]        out_instr_id,
    output logic [2:0]        out_unit_id,
    output logic [6:0]        out_reg_dst,
    output logic [LAT_W-1:0]  out_latency,
    output logic              out_reg_wr,
    output logic [PERF_W-1:0] stall_count
);

    // ------------------------------------------------------------------
    // Source readiness: an unused source never blocks issue.
    // ------------------------------------------------------------------
    function automatic logic src_ready(input logic used, input logic [CNT_W-1:0] cnt);
`ifdef EVEN_SB_FORWARD_EN
        src_ready = !used || (cnt <= CNT_W'(1));
`else
        src_ready = !used || (cnt == CNT_W'(0));
`endif
    endfunction

    // Per-register countdown state
    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];

    // Output pipeline registers
    logic              out_valid_q,    out_valid_d;
    logic [6:0]        out_instr_id_q, out_instr_id_d;
    logic [2:0]        out_unit_id_q,  out_unit_id_d;
    logic [6:0]        out_reg_dst_q,  out_reg_dst_d;
    logic [LAT_W-1:0]  out_latency_q,  out_latency_d;
    logic              out_reg_wr_q,   out_reg_wr_d;
    logic [PERF_W-1:0] stall_q,        stall_d;

    // Hazard / issue signals
    logic [LAT_W-1:0]  eff_lat_s;
    logic [CNT_W-1:0]  load_val_s;
    logic              raw_s;
    logic              waw_s;
    logic              ready_s;
    logic              fire_s;
    logic              stall_s;

    // Latency 0 behaves as 1; the load value adds the write-back stage.
    always_comb begin
        if (in_latency == LAT_W'(0)) begin
            eff_lat_s = LAT_W'(1);
        end else begin
            eff_lat_s = in_latency;
        end
        load_val_s = CNT_W'(eff_lat_s) + CNT_W'(1);
    end

    // Hazard detection against the pre-update countdowns (covers src == own dst).
    always_comb begin
        raw_s = !src_ready(in_ra_used, cnt_q[in_ra_addr]) ||
                !src_ready(in_rb_used, cnt_q[in_rb_addr]) ||
                !src_ready(in_rc_used, cnt_q[in_rc_addr]);
        // An older long-latency write must never land after a younger short one.
        if (in_reg_wr) begin
            waw_s = (cnt_q[in_reg_dst] > load_val_s);
        end else begin
            waw_s = 1'b0;
        end
        ready_s = !(raw_s || waw_s);
        fire_s  = in_valid && ready_s;
        stall_s = in_valid && !ready_s;
    end

    assign in_ready = ready_s;

    // Countdown next state: a new load wins over the decrement of an expiring entry.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            if (fire_s && in_reg_wr && (in_reg_dst == 7'(r))) begin
                cnt_d[r] = load_val_s;
            end else if (cnt_q[r] != CNT_W'(0)) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
    end

    // Countdown register array; reset discards all in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= CNT_W'(0);
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Output field next state: load on fire, otherwise drop valid/reg_wr and hold the rest.
    always_comb begin
        out_valid_d    = 1'b0;
        out_reg_wr_d   = 1'b0;
        out_instr_id_d = out_instr_id_q;
        out_unit_id_d  = out_unit_id_q;
        out_reg_dst_d  = out_reg_dst_q;
        out_latency_d  = out_latency_q;
        if (fire_s) begin
            out_valid_d    = 1'b1;
            out_reg_wr_d   = in_reg_wr;
            out_instr_id_d = in_instr_id;
            out_unit_id_d  = in_unit_id;
            out_reg_dst_d  = in_reg_dst;
            out_latency_d  = in_latency;
        end else begin
            out_valid_d    = 1'b0;
            out_reg_wr_d   = 1'b0;
        end
    end

    // Saturating stall counter next state.
    always_comb begin
        if (stall_s && (stall_q != {PERF_W{1'b1}})) begin
            stall_d = stall_q + PERF_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // Output and performance registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_reg_wr_q   <= 1'b0;
            out_instr_id_q <= 7'd0;
            out_unit_id_q  <= 3'd0;
            out_reg_dst_q  <= 7'd0;
            out_latency_q  <= LAT_W'(0);
            stall_q        <= PERF_W'(0);
        end else begin
            out_valid_q    <= out_valid_d;
            out_reg_wr_q   <= out_reg_wr_d;
            out_instr_id_q <= out_instr_id_d;
            out_unit_id_q  <= out_unit_id_d;
            out_reg_dst_q  <= out_reg_dst_d;
            out_latency_q  <= out_latency_d;
            stall_q        <= stall_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_reg_wr   = out_reg_wr_q;
    assign out_instr_id = out_instr_id_q;
    assign out_unit_id  = out_unit_id_q;
    assign out_reg_dst  = out_reg_dst_q;
    assign out_latency  = out_latency_q;
    assign stall_count  = stall_q;

endmodule

// File: tb/tb_even_issue_scoreboard.sv
// Self-checking bench for even_issue_scoreboard (PERF_W=4 so that counter
// saturation is reachable). The driver pushes expected issued fields into a
// queue; a monitor compares them whenever out_valid is seen.
`timescale 1ns/1ps

module tb_even_issue_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_instr_id;
    logic [2:0] in_unit_id;
    logic [6:0] in_reg_dst;
    logic [3:0] in_latency;
    logic       in_reg_wr;
    logic [6:0] in_ra_addr, in_rb_addr, in_rc_addr;
    logic       in_ra_used, in_rb_used, in_rc_used;
    logic       out_valid;
    logic [6:0] out_instr_id;
    logic [2:0] out_unit_id;
    logic [6:0] out_reg_dst;
    logic [3:0] out_latency;
    logic       out_reg_wr;
    logic [3:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [21:0] exp_q [$];

`ifdef EVEN_SB_FORWARD_EN
    localparam int RAW_STALLS  = 2;
    localparam int LAT0_STALLS = 1;
    localparam int SAT_STALLS  = 7;
`else
    localparam int RAW_STALLS  = 3;
    localparam int LAT0_STALLS = 2;
    localparam int SAT_STALLS  = 8;
`endif

    even_issue_scoreboard #(.NREG(128), .LAT_W(4), .CNT_W(5), .PERF_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr_id(in_instr_id), .in_unit_id(in_unit_id), .in_reg_dst(in_reg_dst),
        .in_latency(in_latency), .in_reg_wr(in_reg_wr),
        .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr), .in_rc_addr(in_rc_addr),
        .in_ra_used(in_ra_used), .in_rb_used(in_rb_used), .in_rc_used(in_rc_used),
        .out_valid(out_valid), .out_instr_id(out_instr_id), .out_unit_id(out_unit_id),
        .out_reg_dst(out_reg_dst), .out_latency(out_latency), .out_reg_wr(out_reg_wr),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare issued fields whenever the DUT presents out_valid.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    check("out_fields",
                          {10'd0, out_instr_id, out_unit_id, out_reg_dst, out_latency, out_reg_wr},
                          {10'd0, exp_q.pop_front()});
                end
            end else begin
                check("out_reg_wr_idle", {31'd0, out_reg_wr}, 32'd0);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Present an instruction; expect in_ready=0 for 'stalls' cycles, then issue.
    task automatic issue(input logic [6:0] id, input logic [2:0] unit, input logic [6:0] dst,
                         input logic [3:0] lat, input logic wr,
                         input logic [6:0] ra, input logic rau,
                         input logic [6:0] rb, input logic rbu,
                         input logic [6:0] rc, input logic rcu, input int stalls);
        in_instr_id = id; in_unit_id = unit; in_reg_dst = dst; in_latency = lat;
        in_reg_wr = wr; in_ra_addr = ra; in_ra_used = rau; in_rb_addr = rb;
        in_rb_used = rbu; in_rc_addr = rc; in_rc_used = rcu; in_valid = 1'b1;
        for (int k = 0; k <= stalls; k++) begin
            @(negedge clk);
            check("in_ready", {31'd0, in_ready}, (k == stalls) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            if (k == stalls) exp_q.push_back({id, unit, dst, lat, wr});
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int exp_stalls);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 32'd0);
        check("stall_count", {28'd0, stall_count}, exp_stalls);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr_id = '0; in_unit_id = '0; in_reg_dst = '0;
        in_latency = '0; in_reg_wr = 1'b0; in_ra_addr = '0; in_rb_addr = '0; in_rc_addr = '0;
        in_ra_used = 1'b0; in_rb_used = 1'b0; in_rc_used = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        check("rst_out_reg_wr", {31'd0, out_reg_wr}, 32'd0);
        check("rst_out_fields", {10'd0, out_instr_id, out_unit_id, out_reg_dst, out_latency, out_reg_wr}, 32'd0);
        check("rst_stall",      {28'd0, stall_count}, 32'd0);
        @(posedge clk); #1;

        // RAW: dst=5 lat=2, then read r5
        issue(7'd1, 3'd0, 7'd5, 4'd2, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0);
        issue(7'd2, 3'd1, 7'd6, 4'd1, 1'b1, 7'd5, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, RAW_STALLS);
        drain(RAW_STALLS);

        // Independent back-to-back stream
        do_reset();
        issue(7'd3, 3'd0, 7'd1, 4'd6, 1'b1, 7'd10, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 0);
        issue(7'd4, 3'd1, 7'd2, 4'd6, 1'b1, 7'd11, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 0);
        issue(7'd5, 3'd2, 7'd3, 4'd6, 1'b1, 7'd12, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 0);
        drain(0);

        // WAW: dst=7 lat=7, then dst=7 lat=2 waits for cnt<=3
        do_reset();
        issue(7'd6, 3'd3, 7'd7, 4'd7, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0);
        issue(7'd7, 3'd0, 7'd7, 4'd2, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 5);
        drain(5);

        // Unused source: rb=5 unused while cnt[5]=4
        do_reset();
        issue(7'd8, 3'd0, 7'd5, 4'd3, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0);
        issue(7'd9, 3'd2, 7'd6, 4'd3, 1'b0, 7'd40, 1'b1, 7'd5, 1'b0, 7'd0, 1'b0, 0);
        drain(0);

        // Latency 0 behaves as 1 (cnt loads 2); out_latency keeps the raw value
        do_reset();
        issue(7'd10, 3'd1, 7'd30, 4'd0, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0);
        issue(7'd11, 3'd1, 7'd31, 4'd1, 1'b1, 7'd0, 1'b0, 7'd30, 1'b1, 7'd0, 1'b0, LAT0_STALLS);
        drain(LAT0_STALLS);

        // Mid-operation reset: dst=9 lat=7 issued, rst two cycles later
        do_reset();
        issue(7'd12, 3'd0, 7'd9, 4'd7, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0);
        in_instr_id = 7'd13; in_reg_dst = 7'd50; in_ra_addr = 7'd9; in_ra_used = 1'b1;
        in_rb_used = 1'b0; in_rc_used = 1'b0; in_reg_wr = 1'b1; in_latency = 4'd1;
        in_valid = 1'b1;
        @(negedge clk);
        check("midrst_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("midrst_stall_pre", {28'd0, stall_count}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_stall",     {28'd0, stall_count}, 32'd0);
        @(posedge clk); #1;
        issue(7'd14, 3'd2, 7'd51, 4'd3, 1'b1, 7'd9, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 0);
        drain(0);

        // Saturation: repeated self-dependent long-latency writes on r20 (src == dst)
        do_reset();
        issue(7'd15, 3'd0, 7'd20, 4'd7, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0);
        issue(7'd16, 3'd3, 7'd20, 4'd7, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd20, 1'b1, SAT_STALLS);
        check("sat_partial", {28'd0, stall_count}, SAT_STALLS);
        issue(7'd17, 3'd3, 7'd20, 4'd7, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd20, 1'b1, SAT_STALLS);
        issue(7'd18, 3'd3, 7'd20, 4'd7, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd20, 1'b1, SAT_STALLS);
        drain(15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
